// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// with bounded locked bursts and a 1-cycle registered read-valid return path.
module spram_rr_arbiter #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_data_out,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_wr_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_data_out,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} st_e;

  st_e             st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_b_q, last_b_d;  // 1: B won the most recent transfer
  logic            a_rvalid_q, b_rvalid_q;
  logic            at_max;
  logic [CntW-1:0] cnt_inc;

  assign at_max  = (cnt_q == CntMax);
  assign cnt_inc = at_max ? cnt_q : cnt_q + CntW'(1);

  // Owner keeps the RAM unless its burst is exhausted and the other side is waiting.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (st_q == StOwnA && a_req && !(at_max && b_req)) begin
      a_gnt = 1'b1;
    end else if (st_q == StOwnB && b_req && !(at_max && a_req)) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (last_b_q) a_gnt = 1'b1;
      else          b_gnt = 1'b1;
    end else if (a_req) begin
      a_gnt = 1'b1;
    end else if (b_req) begin
      b_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_wr_en   = (a_gnt & a_wr_en) | (b_gnt & b_wr_en);
    ram_addr    = b_gnt ? b_addr    : a_addr;
    ram_data_in = b_gnt ? b_data_in : a_data_in;
  end

  always_comb begin
    st_d     = StIdle;
    cnt_d    = '0;
    last_b_d = last_b_q;
    if (a_gnt) begin
      last_b_d = 1'b0;
      if (a_lock) begin
        st_d  = StOwnA;
        cnt_d = (st_q == StOwnA) ? cnt_inc : CntW'(1);
      end
    end else if (b_gnt) begin
      last_b_d = 1'b1;
      if (b_lock) begin
        st_d  = StOwnB;
        cnt_d = (st_q == StOwnB) ? cnt_inc : CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_gnt & ~a_wr_en;
      b_rvalid_q <= b_gnt & ~b_wr_en;
    end
  end

  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_data_out = ram_data_out;
  assign b_data_out = ram_data_out;

endmodule
